// File: rtl/can_tx_scheduler.sv
// Purpose : shares one CAN node transmitter among NUM_REQ mailboxes, lowest 11-bit ID first,
//           with lost-arbitration retry/backoff, a WAIT_DONE timeout and per-requester ack/fail pulses.
// Latency : req_valid rising in IDLE -> tx_start 3 can_clk cycles later when tx_busy is low;
//           tx_done -> req_ack one cycle later.
// Backpressure: tx_busy holds the scheduler in LAUNCH; requesters hold req_valid until ack/fail.
// Ports   : can_clk/reset (async, active-high); req_valid/req_id/req_dlc/req_data packed per requester;
//           req_ack/req_fail one-cycle pulses; tx_start/tx_id/tx_dlc/tx_data frame to the node;
//           tx_busy/tx_done/tx_lost_arb status from the node; sched_state for debug.
module can_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int RETRY_MAX   = 8,
  parameter int BACKOFF_CYC = 11,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  can_clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*11-1:0] req_id,
  input  logic [NUM_REQ*4-1:0]  req_dlc,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_fail,
  output logic                  tx_start,
  output logic [10:0]           tx_id,
  output logic [3:0]            tx_dlc,
  output logic [63:0]           tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  input  logic                  tx_lost_arb,
  output logic [2:0]            sched_state
);

  localparam int WIN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RTY_W   = $clog2(RETRY_MAX + 1);
  localparam int TMR_MAX = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_BACKOFF   = 3'd4
  } state_t;

  state_t             state;
  logic [WIN_W-1:0]   winner;
  logic [RTY_W-1:0]   retry_cnt;
  logic [RTY_W-1:0]   retry_nxt;
  logic [TMR_W-1:0]   timer;

  // Lowest-ID search. Strict less-than while scanning upward keeps ties on the lowest index.
  logic               arb_any;
  logic [WIN_W-1:0]   arb_idx;
  logic [10:0]        arb_id;
  logic [3:0]         arb_dlc;
  logic [63:0]        arb_data;

  always_comb begin
    arb_any  = 1'b0;
    arb_idx  = '0;
    arb_id   = '1;
    arb_dlc  = '0;
    arb_data = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (req_valid[n] && (!arb_any || (req_id[n*11 +: 11] < arb_id))) begin
        arb_any  = 1'b1;
        arb_idx  = n[WIN_W-1:0];
        arb_id   = req_id[n*11 +: 11];
        arb_dlc  = req_dlc[n*4 +: 4];
        arb_data = req_data[n*64 +: 64];
      end
    end
  end

  assign retry_nxt   = retry_cnt + 1'b1;
  assign sched_state = state;

  always_ff @(posedge can_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      winner    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      req_ack   <= '0;
      req_fail  <= '0;
      tx_start  <= 1'b0;
      tx_id     <= '0;
      tx_dlc    <= '0;
      tx_data   <= '0;
    end else begin
      req_ack  <= '0;
      req_fail <= '0;
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) state <= S_ARB;
        end

        S_ARB: begin
          // A requester may have withdrawn between IDLE and ARB.
          if (!arb_any) begin
            state <= S_IDLE;
          end else begin
            winner  <= arb_idx;
            tx_id   <= arb_id;
            tx_dlc  <= (arb_dlc > 4'd8) ? 4'd8 : arb_dlc;
            tx_data <= arb_data;
            // A different frame (e.g. a lower ID arriving during backoff) starts a fresh retry history.
            if (arb_idx != winner) retry_cnt <= '0;
            state <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            timer    <= '0;
            state    <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          timer <= timer + 1'b1;
          // Completion outranks a simultaneous lost-arbitration report.
          if (tx_done) begin
            req_ack[winner] <= 1'b1;
            retry_cnt       <= '0;
            state           <= S_IDLE;
          end else if (tx_lost_arb) begin
            if (retry_nxt == RTY_W'(RETRY_MAX)) begin
              req_fail[winner] <= 1'b1;
              retry_cnt        <= '0;
              state            <= S_IDLE;
            end else begin
              retry_cnt <= retry_nxt;
              timer     <= '0;
              state     <= S_BACKOFF;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            // A timed-out frame is finished; its retry history goes with it.
            req_fail[winner] <= 1'b1;
            retry_cnt        <= '0;
            state            <= S_IDLE;
          end
        end

        S_BACKOFF: begin
          if (timer == TMR_W'(BACKOFF_CYC - 1)) begin
            timer <= '0;
            state <= S_ARB;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
module tb_can_tx_scheduler;

  localparam int NUM_REQ = 4;

  logic                  can_clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*11-1:0] req_id;
  logic [NUM_REQ*4-1:0]  req_dlc;
  logic [NUM_REQ*64-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    req_fail;
  logic                  tx_start;
  logic [10:0]           tx_id;
  logic [3:0]            tx_dlc;
  logic [63:0]           tx_data;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  tx_lost_arb;
  logic [2:0]            sched_state;

  can_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .RETRY_MAX(8), .BACKOFF_CYC(11), .TIMEOUT_CYC(256)
  ) dut (
    .can_clk(can_clk), .reset(reset),
    .req_valid(req_valid), .req_id(req_id), .req_dlc(req_dlc), .req_data(req_data),
    .req_ack(req_ack), .req_fail(req_fail),
    .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_lost_arb(tx_lost_arb),
    .sched_state(sched_state)
  );

  always #5 can_clk = ~can_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  always @(posedge can_clk) cyc_cnt++;

  // kind: 0 = tx_start frame, 1 = ack, 2 = fail
  typedef struct {
    int          kind;
    int          idx;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int kind, input int idx, input logic [10:0] id,
                          input logic [3:0] dlc, input logic [63:0] data);
    exp_t e;
    e.kind = kind; e.idx = idx; e.id = id; e.dlc = dlc; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_start(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    push_exp(0, 0, id, dlc, data);
  endtask

  task automatic set_req(input int idx, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    req_id[idx*11 +: 11]  = id;
    req_dlc[idx*4 +: 4]   = dlc;
    req_data[idx*64 +: 64] = data;
  endtask

  // Monitor: pops one expectation per observed DUT event.
  exp_t m_e;
  always @(negedge can_clk) begin
    if (!reset) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_start: id %0h with no expectation", tx_id);
        end else begin
          m_e = exp_q.pop_front();
          check("start_kind", 80'(0), 80'(m_e.kind));
          check("start_frame", {1'b0, tx_id, tx_dlc, tx_data}, {1'b0, m_e.id, m_e.dlc, m_e.data});
        end
      end
      if ((req_ack | req_fail) != 0) begin
        check("resp_onehot", 80'($countones({req_ack, req_fail})), 80'(1));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ack[i] || req_fail[i]) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_resp: ack %0b fail %0b with no expectation", req_ack, req_fail);
          end else begin
            m_e = exp_q.pop_front();
            check("resp_kind_idx", 80'((req_ack[i] ? 1 : 2) * 16 + i), 80'(m_e.kind * 16 + m_e.idx));
          end
        end
      end
    end
  end

  task automatic wait_start(input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge can_clk);
      cyc++;
    end while (!tx_start && cyc < lim);
    check("start_seen", 80'(tx_start), 80'(1));
  endtask

  task automatic wait_resp(input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge can_clk);
      cyc++;
    end while (((req_ack | req_fail) == 0) && cyc < lim);
    check("resp_seen", 80'(|{req_ack, req_fail}), 80'(1));
  endtask

  task automatic finish_ok(input int idx);
    push_exp(1, idx, '0, '0, '0);
    tx_done = 1'b1;
    @(negedge can_clk);
    tx_done = 1'b0;
    req_valid[idx] = 1'b0;
    check("ack_to_idle", 80'(sched_state), 80'(0));
  endtask

  task automatic lose(input bit last, input int idx);
    if (last) push_exp(2, idx, '0, '0, '0);
    tx_lost_arb = 1'b1;
    @(negedge can_clk);
    tx_lost_arb = 1'b0;
    if (last) begin
      req_valid[idx] = 1'b0;
      check("fail_to_idle", 80'(sched_state), 80'(0));
    end else begin
      check("lost_to_backoff", 80'(sched_state), 80'(4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1);
  end

  initial begin
    int c;
    int last_start;
    reset = 1'b1;
    req_valid = '0; req_id = '0; req_dlc = '0; req_data = '0;
    tx_busy = 1'b0; tx_done = 1'b0; tx_lost_arb = 1'b0;
    repeat (3) @(negedge can_clk);
    check("rst_state", 80'(sched_state), 80'(0));
    check("rst_tx", {tx_start, tx_id, tx_dlc, tx_data}, 80'(0));
    check("rst_resp", 80'({req_ack, req_fail}), 80'(0));
    reset = 1'b0;
    @(negedge can_clk);

    // Single request: 3-cycle latency, then ack.
    set_req(1, 11'h123, 4'd1, 64'h89);
    expect_start(11'h123, 4'd1, 64'h89);
    req_valid[1] = 1'b1;
    wait_start(10, c);
    check("single_latency", 80'(c), 80'(3));
    check("single_wait_state", 80'(sched_state), 80'(3));
    finish_ok(1);

    // Priority: req2 and req3 tie on 0x0A5 (lowest index wins), req0 last.
    set_req(0, 11'h300, 4'd2, 64'h0A0B);
    set_req(2, 11'h0A5, 4'd3, 64'hC0C1C2);
    set_req(3, 11'h0A5, 4'd4, 64'hD0D1D2D3);
    req_valid = 4'b1101;
    expect_start(11'h0A5, 4'd3, 64'hC0C1C2);
    wait_start(10, c);
    finish_ok(2);
    expect_start(11'h0A5, 4'd4, 64'hD0D1D2D3);
    wait_start(10, c);
    finish_ok(3);
    expect_start(11'h300, 4'd2, 64'h0A0B);
    wait_start(10, c);
    finish_ok(0);

    // Eight lost arbitrations -> eight launches, then a single fail.
    set_req(1, 11'h055, 4'd8, 64'h1122334455667788);
    req_valid[1] = 1'b1;
    last_start = 0;
    for (int a = 0; a < 8; a++) begin
      expect_start(11'h055, 4'd8, 64'h1122334455667788);
      wait_start(60, c);
      if (a > 0) check("backoff_gap_ge12", 80'((cyc_cnt - last_start) >= 12), 80'(1));
      last_start = cyc_cnt;
      lose(a == 7, 1);
    end

    // Fresh retry budget: seven losses are tolerated, eighth attempt succeeds.
    req_valid[1] = 1'b1;
    for (int a = 0; a < 7; a++) begin
      expect_start(11'h055, 4'd8, 64'h1122334455667788);
      wait_start(60, c);
      lose(1'b0, 1);
    end
    expect_start(11'h055, 4'd8, 64'h1122334455667788);
    wait_start(60, c);
    finish_ok(1);

    // Preemption during backoff by a lower ID.
    set_req(0, 11'h200, 4'd2, 64'hAA55);
    req_valid[0] = 1'b1;
    expect_start(11'h200, 4'd2, 64'hAA55);
    wait_start(10, c);
    lose(1'b0, 0);
    @(negedge can_clk);
    set_req(1, 11'h010, 4'd1, 64'h77);
    req_valid[1] = 1'b1;
    expect_start(11'h010, 4'd1, 64'h77);
    wait_start(60, c);
    finish_ok(1);
    expect_start(11'h200, 4'd2, 64'hAA55);
    wait_start(10, c);
    finish_ok(0);

    // tx_busy holds the launch; then done + lost together -> ack only.
    tx_busy = 1'b1;
    set_req(2, 11'h321, 4'd5, 64'h5555);
    req_valid[2] = 1'b1;
    repeat (20) @(negedge can_clk);
    check("busy_hold_state", 80'(sched_state), 80'(2));
    check("busy_no_start", 80'(tx_start), 80'(0));
    expect_start(11'h321, 4'd5, 64'h5555);
    tx_busy = 1'b0;
    wait_start(5, c);
    check("busy_release_lat", 80'(c), 80'(1));
    push_exp(1, 2, '0, '0, '0);
    tx_done = 1'b1;
    tx_lost_arb = 1'b1;
    @(negedge can_clk);
    tx_done = 1'b0;
    tx_lost_arb = 1'b0;
    req_valid[2] = 1'b0;
    check("done_lost_idle", 80'(sched_state), 80'(0));
    @(negedge can_clk);
    check("done_lost_stays_idle", 80'(sched_state), 80'(0));

    // Timeout after 256 WAIT_DONE cycles; DLC 0xF clamps to 8.
    set_req(3, 11'h7FF, 4'hF, 64'hFEDCBA9876543210);
    req_valid[3] = 1'b1;
    expect_start(11'h7FF, 4'd8, 64'hFEDCBA9876543210);
    wait_start(10, c);
    push_exp(2, 3, '0, '0, '0);
    wait_resp(300, c);
    check("timeout_cycles", 80'(c), 80'(256));
    check("timeout_id_stable", 80'(tx_id), 80'(11'h7FF));
    req_valid[3] = 1'b0;

    // Asynchronous reset mid-WAIT_DONE, then re-arbitration of the pending request.
    @(negedge can_clk);
    set_req(0, 11'h0F0, 4'd2, 64'hBEEF);
    req_valid[0] = 1'b1;
    expect_start(11'h0F0, 4'd2, 64'hBEEF);
    wait_start(10, c);
    repeat (5) @(negedge can_clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 80'(sched_state), 80'(0));
    check("async_rst_tx", {tx_start, tx_id, tx_dlc, tx_data}, 80'(0));
    tx_done = 1'b1;
    @(negedge can_clk);
    tx_done = 1'b0;
    check("rst_no_resp", 80'({req_ack, req_fail}), 80'(0));
    reset = 1'b0;
    expect_start(11'h0F0, 4'd2, 64'hBEEF);
    wait_start(10, c);
    check("post_rst_latency", 80'(c), 80'(3));
    finish_ok(0);

    repeat (5) @(negedge can_clk);
    check("scoreboard_drained", 80'(exp_q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares one custom CAN node transmitter among NUM_REQ local requesters (mailboxes).
- Picks the pending frame with the lowest 11-bit identifier, which matches CAN bus priority, and hands it to the node with a start/done handshake.
- Retries after lost bus arbitration and reports per-requester completion or failure.
- Sits between the application mailboxes and the CAN node TX datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RETRY_MAX, 8, lost-arbitration attempts allowed before a frame is failed.
- BACKOFF_CYC, 11, can_clk cycles idled after lost arbitration before re-arbitrating (11 = bus-idle recessive bits).
- TIMEOUT_CYC, 256, maximum can_clk cycles in WAIT_DONE before the frame is failed.

Ports:
- can_clk  in  1  bit clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- req_valid  in  NUM_REQ  per-requester pending flag; held high until req_ack or req_fail.
- req_id  in  NUM_REQ*11  packed identifiers; requester n uses [n*11+:11].
- req_dlc  in  NUM_REQ*4  packed data length codes.
- req_data  in  NUM_REQ*64  packed payloads; byte 0 in the LSBs.
- req_ack  out  NUM_REQ  one-cycle pulse when the frame transmitted successfully.
- req_fail  out  NUM_REQ  one-cycle pulse on retry exhaustion or timeout.
- tx_start  out  1  one-cycle launch pulse to the node.
- tx_id  out  11  registered identifier; stable from tx_start until the frame resolves.
- tx_dlc  out  4  registered DLC, clamped to 8.
- tx_data  out  64  registered payload.
- tx_busy  in  1  node is mid-frame or the bus is busy.
- tx_done  in  1  pulse: frame sent including EOF.
- tx_lost_arb  in  1  pulse: node detected bus mismatch and was kicked off.
- sched_state  out  3  current state, for LEDs/debug.

Behaviour:
- Reset values: req_ack, req_fail, tx_start, tx_id, tx_dlc, tx_data all 0; sched_state = IDLE; retry_cnt = 0; timer = 0; winner = 0. Reset asserted mid-frame aborts immediately with no ack or fail pulse.
- States: IDLE=0, ARB=1, LAUNCH=2, WAIT_DONE=3, BACKOFF=4.
- IDLE: go to ARB when any req_valid bit is set.
- ARB (exactly 1 cycle):
  - winner = index with the smallest req_id among valid requesters; ties go to the lowest index.
  - Latch tx_id/tx_dlc/tx_data from the winner. tx_dlc = min(req_dlc, 8).
  - If the winner differs from the previous winner, clear retry_cnt.
  - If no req_valid is set (a requester withdrew), return to IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH: wait while tx_busy = 1. When tx_busy = 0, pulse tx_start for 1 cycle, clear timer, go to WAIT_DONE.
  - Latency: req_valid rising in IDLE to tx_start is 3 cycles when the bus is idle.
- WAIT_DONE: timer increments each cycle.
  - tx_done: pulse req_ack[winner] next cycle, clear retry_cnt, go to IDLE.
  - tx_lost_arb (without tx_done): retry_cnt += 1.
    - If the new retry_cnt == RETRY_MAX, pulse req_fail[winner], clear retry_cnt, go to IDLE.
    - Otherwise go to BACKOFF.
  - timer == TIMEOUT_CYC-1 with no event: pulse req_fail[winner], go to IDLE.
  - tx_done and tx_lost_arb in the same cycle: done wins.
- BACKOFF: count BACKOFF_CYC cycles, then go to ARB. Re-arbitration lets a newly arrived lower ID preempt the retried frame.
- req_valid dropping during LAUNCH/WAIT_DONE does not abort the frame; the ack/fail pulse is still issued.
- tx_* outputs change only in ARB; they are never modified while the node owns the frame.
- At most one bit of req_ack|req_fail is high in any cycle.
- sched_state mirrors the state register.

Test Plan:
- Single request: req_valid[1]=1, id 0x123, dlc 1, data 0x89, tx_busy=0 -> tx_start 3 cycles after req_valid, tx_id=0x123, tx_dlc=1, tx_data[7:0]=0x89. Then tx_done -> req_ack[1] pulse for 1 cycle, state returns to IDLE.
- Priority: req0 id 0x300, req2 id 0x0A5, req3 id 0x0A5, all valid -> winner req2. After its ack, req3 is served, then req0.
- Lost arbitration: tx_lost_arb pulsed every attempt with RETRY_MAX=8 -> 8 tx_start pulses, each separated by ≥11 BACKOFF cycles, then req_fail[winner] pulses once. The next request starts with retry_cnt=0.
- Preemption: req0 id 0x200 loses arbitration; during BACKOFF req1 raises id 0x010 -> the next tx_start carries 0x010, and retry_cnt resets.
- Edge cases:
  - tx_busy held high 20 cycles in LAUNCH -> no tx_start until it drops.
  - No tx_done for 256 cycles -> req_fail pulse.
  - tx_done and tx_lost_arb together -> ack only.
  - dlc=0xF -> tx_dlc=8.
- Reset mid-WAIT_DONE -> all outputs 0 asynchronously, no ack/fail pulse. After release, a still-pending request is re-arbitrated from IDLE.
